// File: rtl/spi_shift_sequencer.sv
// SPI mode-0 frame sequencer that drives an external parallel/serial shift register.
// Optional feature macro SPI_LSB_FIRST_EN: LSB-first framing (RIGHT shifts, mosi from bit 0).
module spi_shift_sequencer #(
   parameter int WIDTH  = 8,
   parameter int CLKDIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   input  logic [WIDTH-1:0] sr_pout,
   output logic [1:0]       sr_mode,
   output logic [WIDTH-1:0] sr_pin,
   output logic             sr_sin,
   input  logic             miso,
   output logic             mosi,
   output logic             sclk,
   output logic             cs_n,
   output logic             busy,
   output logic [WIDTH-1:0] rx_data,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   localparam logic [1:0] M_HOLD  = 2'd0;
   localparam logic [1:0] M_LEFT  = 2'd1;
   localparam logic [1:0] M_RIGHT = 2'd2;
   localparam logic [1:0] M_PLOAD = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LEAD, S_HIGH, S_LOW, S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    div_cnt;
   logic [BW-1:0]    bit_cnt;
   logic             div_end;
   logic             last_bit;
   logic             shift_now;
   logic [1:0]       shift_mode;
   logic [WIDTH-1:0] shifted;

`ifdef SPI_LSB_FIRST_EN
   assign shift_mode = M_RIGHT;
   assign mosi       = sr_pout[0];
   assign shifted    = {sr_sin, sr_pout[WIDTH-1:1]};
`else
   assign shift_mode = M_LEFT;
   assign mosi       = sr_pout[WIDTH-1];
   assign shifted    = {sr_pout[WIDTH-2:0], sr_sin};
`endif

   assign div_end   = (div_cnt == DIV_LAST);
   assign last_bit  = (bit_cnt == BIT_LAST);
   assign shift_now = (state == S_LOW) && (div_cnt == '0);

   always_comb begin
      state_nxt = state;
      sr_mode   = M_HOLD;
      case (state)
         S_IDLE: if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            sr_mode   = M_PLOAD;
            state_nxt = S_LEAD;
         end
         S_LEAD: if (div_end) state_nxt = S_HIGH;
         S_HIGH: if (div_end) state_nxt = S_LOW;
         S_LOW: begin
            if (div_cnt == '0) sr_mode = shift_mode;
            if (div_end) state_nxt = last_bit ? S_DONE : S_HIGH;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         cs_n    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= '0;
         sr_pin  <= '0;
         sr_sin  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         if ((state_nxt != state) || div_end)
            div_cnt <= '0;
         else if (state inside {S_LEAD, S_HIGH, S_LOW})
            div_cnt <= div_cnt + 1'b1;

         case (state)
            S_IDLE: if (start) begin
               sr_pin <= tx_data;
               busy   <= 1'b1;
            end
            S_LOAD: begin
               cs_n    <= 1'b0;
               bit_cnt <= '0;
            end
            S_LEAD: if (div_end) sclk <= 1'b1;
            S_HIGH: begin
               if (div_cnt == '0) sr_sin <= miso;
               if (div_end) sclk <= 1'b0;
            end
            S_LOW: if (div_end) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (!last_bit) begin
                  sclk <= 1'b1;
               end else begin
                  // Capture on entry to DONE so done is high during the DONE cycle;
                  // with a one-cycle LOW the final shift lands on this same edge.
                  rx_data <= shift_now ? shifted : sr_pout;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               cs_n <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_shift_sequencer.sv
// Bench for spi_shift_sequencer: two instances (CLKDIV=2 and CLKDIV=1) with a shift register
// and SPI slave model, directed and random frames checked against a frame-level model.
module tb_spi_shift_sequencer;
   localparam int W    = 8;
   localparam int DIV0 = 2;
   localparam int DIV1 = 1;
`ifdef SPI_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0]        start   = '0;
   logic [1:0]        miso    = '0;
   logic [1:0][W-1:0] tx_data = '0;
   logic [1:0][W-1:0] sr_pout = '0;
   wire  [1:0][W-1:0] sr_pin, rx_data;
   wire  [1:0][1:0]   sr_mode;
   wire  [1:0]        sr_sin, mosi, sclk, cs_n, busy, done;

   always #5 clk = ~clk;

   spi_shift_sequencer #(.WIDTH(W), .CLKDIV(DIV0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .tx_data(tx_data[0]), .sr_pout(sr_pout[0]),
      .sr_mode(sr_mode[0]), .sr_pin(sr_pin[0]), .sr_sin(sr_sin[0]), .miso(miso[0]), .mosi(mosi[0]),
      .sclk(sclk[0]), .cs_n(cs_n[0]), .busy(busy[0]), .rx_data(rx_data[0]), .done(done[0]));

   spi_shift_sequencer #(.WIDTH(W), .CLKDIV(DIV1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .tx_data(tx_data[1]), .sr_pout(sr_pout[1]),
      .sr_mode(sr_mode[1]), .sr_pin(sr_pin[1]), .sr_sin(sr_sin[1]), .miso(miso[1]), .mosi(mosi[1]),
      .sclk(sclk[1]), .cs_n(cs_n[1]), .busy(busy[1]), .rx_data(rx_data[1]), .done(done[1]));

   // External shift register (not reset, as in the peripheral)
   always @(posedge clk)
      for (int d = 0; d < 2; d++)
         case (sr_mode[d])
            2'd1:    sr_pout[d] <= {sr_pout[d][W-2:0], sr_sin[d]};
            2'd2:    sr_pout[d] <= {sr_sin[d], sr_pout[d][W-1:1]};
            2'd3:    sr_pout[d] <= sr_pin[d];
            default: ;
         endcase

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int pulses[2], shifts[2], busy_cyc[2], done_cnt[2], done_at[2], sidx[2], t_acc[2];
   logic [W-1:0] mosi_seq[2], slave_word[2];
   logic prev_sclk[2], prev_cs[2];

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, d, obs, exp);
      end
   endtask

   // Bit i of a frame in wire order
   function automatic logic wire_bit(input logic [W-1:0] w, input int i);
      if (i >= W) return 1'b0;
      return LSB ? w[i] : w[W-1-i];
   endfunction

   function automatic logic [W-1:0] wire_order(input logic [W-1:0] w);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = wire_bit(w, i);
      return r;
   endfunction

   // One cycle: observe at the falling edge, run the mode-0 slave
   task automatic step();
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (busy[d]) busy_cyc[d]++;
         if (sr_mode[d] == (LSB ? 2'd2 : 2'd1)) shifts[d]++;
         if (done[d]) begin
            done_cnt[d]++;
            done_at[d] = cyc;
         end
         if (sclk[d] && !prev_sclk[d]) begin
            if (pulses[d] < W) mosi_seq[d][pulses[d]] = mosi[d];
            pulses[d]++;
         end
         if (!cs_n[d] && prev_cs[d]) begin
            sidx[d] = 0;
            miso[d] = wire_bit(slave_word[d], 0);
         end else if (!sclk[d] && prev_sclk[d]) begin
            sidx[d]++;
            miso[d] = wire_bit(slave_word[d], sidx[d]);
         end
         prev_sclk[d] = sclk[d];
         prev_cs[d]   = cs_n[d];
      end
   endtask

   task automatic launch(input int d, input logic [W-1:0] tx, input logic [W-1:0] sw);
      pulses[d] = 0; shifts[d] = 0; busy_cyc[d] = 0; done_cnt[d] = 0; done_at[d] = -1;
      mosi_seq[d] = '0;
      slave_word[d] = sw;
      tx_data[d] = tx;
      start[d] = 1'b1;
      chk("idle_at_accept", d, busy[d], 0);
      t_acc[d] = cyc;
   endtask

   task automatic complete(input int d, input logic [W-1:0] tx, input logic [W-1:0] sw, input bit hold);
      int frame, n;
      frame = 2 + ((d == 0) ? DIV0 : DIV1) * (2 * W + 1);
      n = 0;
      step();
      if (!hold) start[d] = 1'b0;
      tx_data[d] = W'($urandom);
      chk("busy_after_accept", d, busy[d], 1);
      chk("cs_high_in_load", d, cs_n[d], 1);
      while (busy[d] && n < frame + 8) begin
         step();
         n++;
      end
      chk("frame_ends", d, busy[d], 0);
      chk("busy_cycles", d, busy_cyc[d], frame);
      chk("done_count", d, done_cnt[d], 1);
      chk("done_latency", d, done_at[d] - t_acc[d], frame);
      chk("rx_data", d, rx_data[d], sw);
      chk("sck_pulses", d, pulses[d], W);
      chk("shift_cycles", d, shifts[d], W);
      chk("mosi_bits", d, mosi_seq[d], wire_order(tx));
      chk("cs_idle", d, cs_n[d], 1);
      chk("sclk_idle", d, sclk[d], 0);
   endtask

   initial begin
      logic [W-1:0] tx, sw;
      int n;
      for (int d = 0; d < 2; d++) begin
         prev_sclk[d] = 1'b0; prev_cs[d] = 1'b1; sidx[d] = 0; slave_word[d] = '0;
         pulses[d] = 0; shifts[d] = 0; busy_cyc[d] = 0; done_cnt[d] = 0; done_at[d] = -1;
         t_acc[d] = 0; mosi_seq[d] = '0;
      end

      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         chk("rst_cs_n", d, cs_n[d], 1);
         chk("rst_sclk", d, sclk[d], 0);
         chk("rst_busy", d, busy[d], 0);
         chk("rst_done", d, done[d], 0);
         chk("rst_rx_data", d, rx_data[d], 0);
         chk("rst_sr_pin", d, sr_pin[d], 0);
         chk("rst_sr_sin", d, sr_sin[d], 0);
         chk("rst_sr_mode", d, sr_mode[d], 0);
      end
      rst_n = 1'b1;

      repeat (20) begin
         step();
         for (int d = 0; d < 2; d++) begin
            chk("idle_cs_n", d, cs_n[d], 1);
            chk("idle_sclk", d, sclk[d], 0);
            chk("idle_busy", d, busy[d], 0);
            chk("idle_done", d, done[d], 0);
            chk("idle_sr_mode", d, sr_mode[d], 0);
         end
      end

      launch(0, 8'hA5, 8'h3C); complete(0, 8'hA5, 8'h3C, 1'b0);
      step();
      launch(1, 8'h80, 8'hFF); complete(1, 8'h80, 8'hFF, 1'b0);
      step();
      launch(0, 8'h01, 8'h01); complete(0, 8'h01, 8'h01, 1'b0);

      // start held through a whole frame: one frame, then re-accept on the first idle cycle
      step();
      launch(0, 8'h5A, 8'hC3); complete(0, 8'h5A, 8'hC3, 1'b1);
      tx = tx_data[0];
      launch(0, tx, 8'h96); complete(0, tx, 8'h96, 1'b0);

      // Asynchronous reset mid-frame
      step();
      launch(0, 8'h69, 8'h5A);
      step();
      start[0] = 1'b0;
      n = 0;
      while (pulses[0] < 3 && n < 200) begin
         step();
         n++;
      end
      chk("three_pulses", 0, pulses[0], 3);
      rst_n = 1'b0;
      #1;
      chk("arst_cs_n", 0, cs_n[0], 1);
      chk("arst_sclk", 0, sclk[0], 0);
      chk("arst_busy", 0, busy[0], 0);
      chk("arst_sr_mode", 0, sr_mode[0], 0);
      repeat (3) step();
      chk("no_done_after_abort", 0, done_cnt[0], 0);
      rst_n = 1'b1;
      step();
      launch(0, 8'hFF, 8'h81); complete(0, 8'hFF, 8'h81, 1'b0);

      for (int i = 0; i < 8; i++) begin
         tx = W'($urandom);
         sw = W'($urandom);
         step();
         launch(i % 2, tx, sw);
         complete(i % 2, tx, sw, 1'b0);
      end

      repeat (4) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
